mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 32 +++
 rtl/mdu_ctrl_if.sv | 29 ++
 rtl/mdu_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared CPU constants for the HI/LO issue controller:
// E-stage op codes, HI/LO unit type codes and controller states.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    localparam logic [3:0] MDT_NONE = 4'b0000;
    localparam logic [3:0] MDT_MUL  = 4'b0001;
    localparam logic [3:0] MDT_DIV  = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // Codes 9..15 are not HI/LO ops and behave as NONE.
    function automatic logic is_md_op(logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> HI/LO controller signal bundle.
// master: pipeline side; slave: the controller.
interface mdu_ctrl_if;

    logic       req;
    logic [3:0] e_op;
    logic       d_uses_md;
    logic       md_start;
    logic [3:0] md_type;
    logic       md_unsigned;
    logic       md_write;
    logic       md_dst;
    logic       busy;
    logic       stall;
    logic       proto_err;

    modport master (
        output req, e_op, d_uses_md,
        input  md_start, md_type, md_unsigned, md_write,
        input  md_dst, busy, stall, proto_err
    );

    modport slave (
        input  req, e_op, d_uses_md,
        output md_start, md_type, md_unsigned, md_write,
        output md_dst, busy, stall, proto_err
    );

endinterface

// File: rtl/mdu_ctrl.sv
// HI/LO issue controller: issues mul/div, tracks occupancy,
// stalls dependent D-stage ops and flags ops that hit E while busy.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  md
);

    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       perr_q, perr_d;

    logic idle, is_mul, is_div, is_uns, is_mt, issue;

    assign idle   = (state_q == ST_IDLE);
    assign is_mul = (md.e_op == OP_MULT) || (md.e_op == OP_MULTU);
    assign is_div = (md.e_op == OP_DIV)  || (md.e_op == OP_DIVU);
    assign is_uns = (md.e_op == OP_MULTU) || (md.e_op == OP_DIVU);
    assign is_mt  = (md.e_op == OP_MTHI) || (md.e_op == OP_MTLO);
    assign issue  = idle && !md.req && (is_mul || is_div);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        perr_d  = perr_q || (!idle && is_md_op(md.e_op));
        unique case (state_q)
            ST_IDLE: begin
                if (issue && is_mul) begin
                    state_d = ST_MUL;
                    cnt_d   = MUL_LAST;
                end else if (issue) begin
                    state_d = ST_DIV;
                    cnt_d   = DIV_LAST;
                end
            end
            ST_MUL, ST_DIV: begin
                // cnt==0 marks the last busy cycle
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        md.md_type = MDT_NONE;
        unique case (1'b1)
            issue && is_mul: md.md_type = MDT_MUL;
            issue && is_div: md.md_type = MDT_DIV;
            default:         md.md_type = MDT_NONE;
        endcase
    end

    assign md.md_start    = issue;
    assign md.md_unsigned = issue && is_uns;
    assign md.md_write    = idle && !md.req && is_mt;
    assign md.md_dst      = (md.e_op == OP_MFHI) || (md.e_op == OP_MTHI);
    assign md.busy        = !idle;
    assign md.stall       = md.d_uses_md && (!idle || issue);
    assign md.proto_err   = perr_q;

endmodule
